// File: rtl/dec_host_driver_pkg.sv
// Shared definitions for the decision-tree classifier host driver.
//   - command / classifier mode encodings
//   - root node index of the classifier tree
//   - driver FSM state type
package dec_host_driver_pkg;

    localparam logic [1:0] MODE_FEA      = 2'b00;  // write feature-index table
    localparam logic [1:0] MODE_THD      = 2'b01;  // write threshold table
    localparam logic [1:0] MODE_CHILD    = 2'b10;  // write child table
    localparam logic [1:0] MODE_CLASSIFY = 2'b11;  // classify one sample

    localparam int ROOT_NODE = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // hold register empty
        ST_ISSUE   = 2'd1,  // hold full, beat offered to the classifier
        ST_BARRIER = 2'd2   // hold full, beat blocked by its gate
    } state_t;

    function automatic logic is_classify(input logic [1:0] mode);
        return mode == MODE_CLASSIFY;
    endfunction

endpackage

// File: rtl/dec_result_fifo.sv
// Synchronous result FIFO for classifier results.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_i         write push_data_i (dropped when full without a pop)
//   push_data_i    entry to store
//   pop_i          remove head entry (ignored when empty)
//   head_o         head entry, read from registered storage
//   empty_o        FIFO empty
//   overflow_o     push refused because FIFO full and not popping
//   count_o        number of stored entries
// DEPTH must be a power of two so pointers wrap by natural overflow.
module dec_result_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_pop, do_push;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i & (~full | do_pop);

    assign overflow_o = push_i & full & ~do_pop;
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_o     = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dec_host_driver.sv
// Host-side driver for the decision-tree classifier core.
// Converts a host command stream into classifier input beats (table writes
// and classify requests) and collects classifier results in a FIFO.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        host command handshake
//   cmd_mode/cmd_data/cmd_id   command fields (id used by classify only)
//   dec_input_*                beat to the classifier, driven from the hold register
//   dec_input_ready            classifier ready (registered once before use)
//   dec_out_valid/_ID/dec_out  classifier result strobe
//   res_valid/res_ready        result FIFO head handshake to the host
//   res_id/res_class           result FIFO head
//   outstanding                classify beats accepted but not yet returned
//   busy                       any work held, in flight or unread
//   err                        sticky protocol error (cleared by rst only)
//   dbg_state_o                driver FSM state
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. cmd_valid/cmd_ready transfer into the hold
// register. A classifier beat transfers when dec_input_data_valid is high
// and the registered copy of dec_input_ready (ready_q) is high, matching
// the classifier's one-cycle-delayed accept. res_valid/res_ready pops the
// result FIFO.
module dec_host_driver
    import dec_host_driver_pkg::*;
#(
    parameter int NUM_FEATURE = 8,
    parameter int ID_W        = 12,
    parameter int RES_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_mode,
    input  logic [8*NUM_FEATURE-1:0]    cmd_data,
    input  logic [ID_W-1:0]             cmd_id,
    output logic                        dec_input_data_valid,
    output logic [8*NUM_FEATURE-1:0]    dec_input_data,
    output logic [1:0]                  dec_input_mode,
    output logic [ID_W-1:0]             dec_input_ID,
    input  logic                        dec_input_ready,
    input  logic                        dec_out_valid,
    input  logic [ID_W-1:0]             dec_out_ID,
    input  logic                        dec_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [ID_W-1:0]             res_id,
    output logic                        res_class,
    output logic [$clog2(RES_DEPTH):0]  outstanding,
    output logic                        busy,
    output logic                        err,
    output logic [1:0]                  dbg_state_o
);

    localparam int DW = 8 * NUM_FEATURE;
    localparam int OW = $clog2(RES_DEPTH) + 1;

    state_t          state_q, state_d;
    logic            ready_q;
    logic [1:0]      hold_mode_q;
    logic [DW-1:0]   hold_data_q;
    logic [ID_W-1:0] hold_id_q;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic            err_q, err_d;

    logic            hold_valid;
    logic [OW:0]     occupancy;
    logic            gate_classify, gate_write, gate_hold, gate_cmd;
    logic            acc, cmd_fire, inc, underflow;
    logic            fifo_empty, fifo_overflow;
    logic [OW-1:0]   fifo_count;
    logic [ID_W:0]   fifo_head;

    assign hold_valid = (state_q != ST_IDLE);

    // Every classify beat will eventually need a FIFO slot, so results in
    // flight and results already stored both count against the depth.
    assign occupancy     = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign gate_classify = (occupancy < (OW+1)'(RES_DEPTH));
    // Table writes wait until no sample is inside the classifier.
    assign gate_write    = (outstanding_q == '0);
    assign gate_hold     = is_classify(hold_mode_q) ? gate_classify : gate_write;
    assign gate_cmd      = is_classify(cmd_mode)    ? gate_classify : gate_write;

    assign dec_input_data_valid = hold_valid & gate_hold;
    assign acc                  = dec_input_data_valid & ready_q;
    assign cmd_ready            = ~hold_valid | acc;
    assign cmd_fire             = cmd_valid & cmd_ready;

    assign dec_input_data = hold_data_q;
    assign dec_input_mode = hold_mode_q;
    assign dec_input_ID   = hold_id_q;

    // ISSUE/BARRIER label follows the gate one cycle late; the valid output
    // always uses the live gate, so both held states accept a beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = gate_cmd ? ST_ISSUE : ST_BARRIER;
                end
            end
            ST_ISSUE, ST_BARRIER: begin
                if (acc) begin
                    if (cmd_fire) begin
                        state_d = gate_cmd ? ST_ISSUE : ST_BARRIER;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = gate_hold ? ST_ISSUE : ST_BARRIER;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outstanding classify count; a same-cycle accept and return cancel.
    assign inc = acc & is_classify(hold_mode_q);

    always_comb begin
        outstanding_d = outstanding_q;
        underflow     = 1'b0;
        case ({inc, dec_out_valid})
            2'b10: outstanding_d = outstanding_q + OW'(1);
            2'b01: begin
                if (outstanding_q == '0) begin
                    underflow = 1'b1;
                end else begin
                    outstanding_d = outstanding_q - OW'(1);
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    assign err_d = err_q | underflow | fifo_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b0;
            hold_mode_q   <= '0;
            hold_data_q   <= '0;
            hold_id_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= dec_input_ready;
            if (cmd_fire) begin
                hold_mode_q <= cmd_mode;
                hold_data_q <= cmd_data;
                hold_id_q   <= cmd_id;
            end
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    dec_result_fifo #(
        .WIDTH (ID_W + 1),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (dec_out_valid),
        .push_data_i ({dec_out_ID, dec_out}),
        .pop_i       (res_valid & res_ready),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .overflow_o  (fifo_overflow),
        .count_o     (fifo_count)
    );

    assign res_valid   = ~fifo_empty;
    assign res_id      = fifo_head[ID_W:1];
    assign res_class   = fifo_head[0];
    assign outstanding = outstanding_q;
    assign busy        = hold_valid | (outstanding_q != '0) | res_valid;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dec_host_driver.sv
// Self-checking bench for dec_host_driver. The bench plays both the host and
// the classifier core; a queue-based reference model tracks the expected
// driver behaviour cycle by cycle.
module tb_dec_host_driver;
    import dec_host_driver_pkg::*;

    localparam int NF  = 8;
    localparam int IDW = 12;
    localparam int D   = 8;
    localparam int DW  = 8 * NF;
    localparam int OW  = $clog2(D) + 1;

    logic            clk, rst;
    logic            cmd_valid, cmd_ready;
    logic [1:0]      cmd_mode;
    logic [DW-1:0]   cmd_data;
    logic [IDW-1:0]  cmd_id;
    logic            dec_input_data_valid;
    logic [DW-1:0]   dec_input_data;
    logic [1:0]      dec_input_mode;
    logic [IDW-1:0]  dec_input_ID;
    logic            dec_input_ready;
    logic            dec_out_valid;
    logic [IDW-1:0]  dec_out_ID;
    logic            dec_out;
    logic            res_valid, res_ready;
    logic [IDW-1:0]  res_id;
    logic            res_class;
    logic [OW-1:0]   outstanding;
    logic            busy, err;
    logic [1:0]      dbg_state;

    dec_host_driver #(.NUM_FEATURE(NF), .ID_W(IDW), .RES_DEPTH(D)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_mode             (cmd_mode),
        .cmd_data             (cmd_data),
        .cmd_id               (cmd_id),
        .dec_input_data_valid (dec_input_data_valid),
        .dec_input_data       (dec_input_data),
        .dec_input_mode       (dec_input_mode),
        .dec_input_ID         (dec_input_ID),
        .dec_input_ready      (dec_input_ready),
        .dec_out_valid        (dec_out_valid),
        .dec_out_ID           (dec_out_ID),
        .dec_out              (dec_out),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_id               (res_id),
        .res_class            (res_class),
        .outstanding          (outstanding),
        .busy                 (busy),
        .err                  (err),
        .dbg_state_o          (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / counters ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [IDW-1:0] id;
        logic           cls;
        int             due;
    } pend_t;

    logic            m_hv;
    logic [1:0]      m_mode;
    logic [DW-1:0]   m_data;
    logic [IDW-1:0]  m_id;
    logic            m_rq;
    int              m_out;
    logic            m_err;
    logic [IDW:0]    res_q[$];     // {id, class} in arrival order
    pend_t           pend_q[$];    // classify requests awaiting a result
    logic            auto_cls;
    logic            last_load;
    int              cyc;
    int              beats3;       // classify beats seen accepted on the DUT pins

    task automatic model_reset();
        m_hv = 1'b0; m_mode = '0; m_data = '0; m_id = '0;
        m_rq = 1'b0; m_out = 0; m_err = 1'b0;
        res_q.delete();
        pend_q.delete();
        last_load = 1'b0;
    endtask

    // One clock cycle: inputs already set (at the falling edge), outputs
    // checked against the model, model advanced, then wait for next negedge.
    task automatic tick();
        logic  gate, e_v, e_acc, e_cr, inc, pop, full;
        pend_t p;
        if (auto_cls) begin
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                dec_out_valid = 1'b1;
                dec_out_ID    = p.id;
                dec_out       = p.cls;
            end else begin
                dec_out_valid = 1'b0;
            end
        end
        #1;
        if (!m_hv) begin
            gate = 1'b0;
        end else if (m_mode == MODE_CLASSIFY) begin
            gate = (m_out + res_q.size()) < D;
        end else begin
            gate = (m_out == 0);
        end
        e_v   = m_hv && gate;
        e_acc = e_v && m_rq;
        e_cr  = !m_hv || e_acc;

        chk("cmd_ready", cmd_ready, e_cr);
        chk("in_valid", dec_input_data_valid, e_v);
        if (e_v) begin
            chk("in_mode", dec_input_mode, m_mode);
            chk("in_data", dec_input_data, m_data);
            chk("in_id", dec_input_ID, m_id);
        end
        chk("outstanding", outstanding, m_out);
        chk("res_valid", res_valid, res_q.size() > 0);
        if (res_q.size() > 0) begin
            chk("res_id", res_id, res_q[0][IDW:1]);
            chk("res_class", res_class, res_q[0][0]);
        end
        chk("err", err, m_err);
        chk("busy", busy, m_hv || (m_out != 0) || (res_q.size() > 0));

        if (dec_input_data_valid && m_rq && dec_input_mode == MODE_CLASSIFY) beats3++;

        inc = e_acc && (m_mode == MODE_CLASSIFY);
        if (inc) begin
            p.id  = m_id;
            p.cls = 1'($urandom_range(0, 1));
            p.due = cyc + 1 + int'($urandom_range(0, 3));
            pend_q.push_back(p);
        end
        if (dec_out_valid) begin
            if (!inc) begin
                if (m_out == 0) m_err = 1'b1;
                else m_out--;
            end
        end else if (inc) begin
            m_out++;
        end
        pop  = (res_q.size() > 0) && res_ready;
        full = (res_q.size() == D);
        if (pop) void'(res_q.pop_front());
        if (dec_out_valid) begin
            if (full && !pop) m_err = 1'b1;
            else res_q.push_back({dec_out_ID, dec_out});
        end
        if (e_acc) m_hv = 1'b0;
        last_load = cmd_valid && e_cr;
        if (last_load) begin
            m_hv = 1'b1; m_mode = cmd_mode; m_data = cmd_data; m_id = cmd_id;
        end
        m_rq = dec_input_ready;
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_mode = '0; cmd_data = '0; cmd_id = '0;
        dec_input_ready = 1'b0; dec_out_valid = 1'b0; dec_out_ID = '0; dec_out = 1'b0;
        res_ready = 1'b0; auto_cls = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", dec_input_data_valid, 1'b0);
        chk("rst_data", dec_input_data, '0);
        chk("rst_outstanding", outstanding, '0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_id", res_id, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_cmd(input logic v, input logic [1:0] mode, input logic [DW-1:0] data,
                           input logic [IDW-1:0] id);
        cmd_valid = v; cmd_mode = mode; cmd_data = data; cmd_id = id;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic           cv;
        logic [1:0]     mode;
        logic [DW-1:0]  data;
        logic [IDW-1:0] id;
        logic           dov;
        logic [IDW-1:0] did;
        logic           rr;
        logic           e_v;
        logic [1:0]     e_mode;
        logic [DW-1:0]  e_data;
        logic [IDW-1:0] e_id;
        logic           e_cr;
        logic [OW-1:0]  e_out;
        logic           e_rv;
        logic [IDW-1:0] e_rid;
        logic           e_rcls;
        logic           e_busy;
    } vec_t;

    vec_t tbl[8];

    logic [DW-1:0] held;
    int            n_issued;

    initial begin
        rst = 1'b1;
        cyc = 0; beats3 = 0;
        @(negedge clk);
        do_reset();

        // Table load then one classify, dec_input_ready high throughout.
        //            cv  mode  data              id      dov did     rr  | e_v e_mode e_data          e_id    e_cr e_out e_rv e_rid   e_rcls e_busy
        tbl[0] = '{1'b1, 2'd0, 64'h0203,       12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 2'd0, 64'h0,        12'h000, 1'b1, 4'd0, 1'b0, 12'h000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 64'h0264,       12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 2'd0, 64'h0203,     12'h000, 1'b1, 4'd0, 1'b0, 12'h000, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 2'd2, 64'h0400,       12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 2'd1, 64'h0264,     12'h000, 1'b1, 4'd0, 1'b0, 12'h000, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 2'd3, 64'h9600_0000,  12'h05A, 1'b0, 12'h000, 1'b0, 1'b1, 2'd2, 64'h0400,     12'h000, 1'b1, 4'd0, 1'b0, 12'h000, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 2'd0, 64'h0,          12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 2'd3, 64'h9600_0000, 12'h05A, 1'b1, 4'd0, 1'b0, 12'h000, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 2'd0, 64'h0,          12'h000, 1'b1, 12'h05A, 1'b0, 1'b0, 2'd0, 64'h0,        12'h000, 1'b1, 4'd1, 1'b0, 12'h000, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 2'd0, 64'h0,          12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 2'd0, 64'h0,        12'h000, 1'b1, 4'd0, 1'b1, 12'h05A, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 2'd0, 64'h0,          12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 2'd0, 64'h0,        12'h000, 1'b1, 4'd0, 1'b0, 12'h000, 1'b0, 1'b0};

        for (int r = 0; r < 8; r++) begin
            set_cmd(tbl[r].cv, tbl[r].mode, tbl[r].data, tbl[r].id);
            dec_input_ready = 1'b1;
            dec_out_valid   = tbl[r].dov;
            dec_out_ID      = tbl[r].did;
            dec_out         = 1'b0;
            res_ready       = tbl[r].rr;
            #1;
            chk($sformatf("tbl%0d_valid", r), dec_input_data_valid, tbl[r].e_v);
            if (tbl[r].e_v) begin
                chk($sformatf("tbl%0d_mode", r), dec_input_mode, tbl[r].e_mode);
                chk($sformatf("tbl%0d_data", r), dec_input_data, tbl[r].e_data);
                chk($sformatf("tbl%0d_id", r), dec_input_ID, tbl[r].e_id);
            end
            chk($sformatf("tbl%0d_cmd_ready", r), cmd_ready, tbl[r].e_cr);
            chk($sformatf("tbl%0d_outstanding", r), outstanding, tbl[r].e_out);
            chk($sformatf("tbl%0d_res_valid", r), res_valid, tbl[r].e_rv);
            if (tbl[r].e_rv) begin
                chk($sformatf("tbl%0d_res_id", r), res_id, tbl[r].e_rid);
                chk($sformatf("tbl%0d_res_class", r), res_class, tbl[r].e_rcls);
            end
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            tick();
        end

        // Write barrier: table write waits for the in-flight classify.
        do_reset();
        dec_input_ready = 1'b1;
        set_cmd(1'b1, MODE_CLASSIFY, 64'h11, 12'h111); tick();
        set_cmd(1'b0, MODE_CLASSIFY, 64'h11, 12'h111); tick();
        set_cmd(1'b1, MODE_FEA, 64'h5, 12'h000);       tick();
        cmd_valid = 1'b0;
        #1; chk("barrier_hold0", dec_input_data_valid, 1'b0); tick();
        #1; chk("barrier_hold1", dec_input_data_valid, 1'b0); tick();
        dec_out_valid = 1'b1; dec_out_ID = 12'h111; dec_out = 1'b1;
        #1; chk("barrier_hold2", dec_input_data_valid, 1'b0); tick();
        dec_out_valid = 1'b0;
        #1; chk("barrier_release", dec_input_data_valid, 1'b1);
        chk("barrier_mode", dec_input_mode, MODE_FEA);
        tick();
        res_ready = 1'b1; tick(); tick();

        // ready_q gating and underflow error.
        do_reset();
        held = {$urandom, $urandom};
        dec_input_ready = 1'b0;
        set_cmd(1'b1, MODE_CLASSIFY, held, 12'h2A5); tick();
        cmd_valid = 1'b0; dec_input_ready = 1'b1;
        #1;
        chk("rq_valid", dec_input_data_valid, 1'b1);
        chk("rq_no_acc", cmd_ready, 1'b0);
        chk("rq_data0", dec_input_data, held);
        tick();
        #1;
        chk("rq_acc", cmd_ready, 1'b1);
        chk("rq_data1", dec_input_data, held);
        tick();
        dec_out_valid = 1'b1; dec_out_ID = 12'h2A5; dec_out = 1'b1; tick();
        dec_out_ID = 12'h7FF; dec_out = 1'b0; tick();
        dec_out_valid = 1'b0;
        #1; chk("underflow_err", err, 1'b1);
        res_ready = 1'b1;
        repeat (4) tick();
        #1; chk("err_sticky", err, 1'b1);

        // Backpressure: result FIFO not drained, ten classifies offered.
        do_reset();
        auto_cls = 1'b1; dec_input_ready = 1'b1; res_ready = 1'b0;
        beats3 = 0; n_issued = 0;
        set_cmd(1'b1, MODE_CLASSIFY, 64'h1, 12'h100);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_load) begin
                n_issued++;
                if (n_issued < 10) cmd_id = 12'h100 + 12'(n_issued);
                else cmd_valid = 1'b0;
            end
        end
        #1;
        chk("bp_beats", beats3, 8);
        chk("bp_cmd_ready", cmd_ready, 1'b0);
        chk("bp_err", err, 1'b0);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_load) begin
                n_issued++;
                cmd_valid = 1'b0;
            end
        end
        chk("bp_ninth", beats3, 9);
        res_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (last_load) cmd_valid = 1'b0;
        end
        chk("bp_all", beats3, 10);
        chk("bp_err_end", err, 1'b0);

        // Reset mid-stream with three classifies in flight.
        do_reset();
        dec_input_ready = 1'b1;
        set_cmd(1'b1, MODE_CLASSIFY, 64'h3, 12'h301); tick();
        cmd_id = 12'h302; tick();
        cmd_id = 12'h303; tick();
        cmd_valid = 1'b0; tick();
        #1; chk("mid_outstanding", outstanding, 4'd3);
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_outstanding", outstanding, 4'd0);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_valid", dec_input_data_valid, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1; chk("mid_err_after", err, 1'b0);
        tick();

        // Randomized traffic against the model.
        do_reset();
        auto_cls = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!cmd_valid || last_load) begin
                cmd_valid = ($urandom_range(0, 3) != 0);
                cmd_mode  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : MODE_CLASSIFY;
                cmd_data  = {$urandom, $urandom};
                cmd_id    = 12'($urandom);
            end
            dec_input_ready = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 99) < (((i / 250) % 2 == 1) ? 15 : 85));
            tick();
        end
        cmd_valid = 1'b0; dec_input_ready = 1'b1; res_ready = 1'b1;
        repeat (40) tick();
        #1;
        chk("rand_idle_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
